// File: rtl/tao_xung_if.sv
// Square-wave generator bus: requested frequency in, wave and status out.
interface tao_xung_if;
   logic [6:0] count;
   logic       wave;
   logic [6:0] freq_cur;
   logic       busy;

   modport master (output count, input wave, freq_cur, busy);
   modport slave  (input count, output wave, freq_cur, busy);
endinterface

// File: rtl/tao_xung.sv
// Programmable square-wave generator. A requested frequency code is turned
// into a half-period count by a sequential restoring divider; the wave keeps
// running at the old period while a new one is computed, and the switch is
// made only on a wave edge so no runt pulse is produced.
module tao_xung #(
   parameter int CLK_HZ = 27000000,
   parameter int FMAX   = 99
) (
   input  logic       main_clk,
   input  logic       rst_n,
   tao_xung_if.slave  bus
);

   localparam logic [6:0]  FMAX_C   = 7'(FMAX);
   localparam logic [24:0] DIVIDEND = 25'(CLK_HZ);

   typedef enum logic [1:0] {IDLE, DIV, LOAD, RUN} state_t;

   state_t      state;
   logic [6:0]  req;
   logic [6:0]  d;
   logic [7:0]  rem;
   logic [24:0] quo;
   logic [4:0]  bit_idx;
   logic        busy_r;
   logic        running;
   logic        wave_r;
   logic [6:0]  freq_r;
   logic [24:0] phase;
   logic [24:0] active;
   logic [24:0] pending;
   logic [6:0]  pend_code;
   logic        pend_vld;

   logic [8:0]  rem_sh;
   logic [7:0]  dvs;
   logic        q_bit;
   logic [7:0]  rem_nxt;
   logic        toggle;

   // Clamp a requested code to the highest supported frequency.
   function automatic logic [6:0] sat_code(input logic [6:0] c);
      return (c > FMAX_C) ? FMAX_C : c;
   endfunction

   // A zero half-period would stall the counter; treat it as one cycle.
   function automatic logic [24:0] fix_half(input logic [24:0] h);
      return (h == 25'd0) ? 25'd1 : h;
   endfunction

   // One restoring-division step: bring down the next dividend bit, subtract 2*d if it fits.
   always_comb begin
      rem_sh  = {rem, DIVIDEND[bit_idx]};
      dvs     = {d, 1'b0};
      q_bit   = (rem_sh >= {1'b0, dvs});
      rem_nxt = q_bit ? 8'(rem_sh - {1'b0, dvs}) : rem_sh[7:0];
      toggle  = running && (phase == active - 25'd1);
   end

   // Sample the requested code every cycle, clamped to the supported range.
   always_ff @(posedge main_clk or negedge rst_n) begin
      if (!rst_n) req <= '0;
      else        req <= sat_code(bus.count);
   end

   // Control FSM plus the free-running wave generator it feeds.
   always_ff @(posedge main_clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         d         <= '0;
         rem       <= '0;
         quo       <= '0;
         bit_idx   <= '0;
         busy_r    <= 1'b0;
         running   <= 1'b0;
         wave_r    <= 1'b0;
         freq_r    <= '0;
         phase     <= '0;
         active    <= '0;
         pending   <= '0;
         pend_code <= '0;
         pend_vld  <= 1'b0;
      end else begin
         // The wave keeps running through DIV and LOAD so the current half-period is never stretched.
         if (running) begin
            if (toggle) begin
               wave_r <= ~wave_r;
               phase  <= '0;
               if (pend_vld) begin
                  active   <= pending;
                  freq_r   <= pend_code;
                  pend_vld <= 1'b0;
               end
            end else begin
               phase <= phase + 25'd1;
            end
         end

         case (state)
            IDLE: begin
               if (req != 7'd0) begin
                  state   <= DIV;
                  d       <= req;
                  busy_r  <= 1'b1;
                  rem     <= '0;
                  quo     <= '0;
                  bit_idx <= 5'd24;
               end
            end

            DIV: begin
               rem <= rem_nxt;
               quo <= {quo[23:0], q_bit};
               if (bit_idx == 5'd0) begin
                  busy_r <= 1'b0;
                  state  <= LOAD;
               end else begin
                  bit_idx <= bit_idx - 5'd1;
               end
            end

            LOAD: begin
               if (!running) begin
                  active  <= fix_half(quo);
                  phase   <= '0;
                  freq_r  <= d;
                  running <= 1'b1;
               end else begin
                  pending   <= fix_half(quo);
                  pend_code <= d;
                  pend_vld  <= 1'b1;
               end
               state <= RUN;
            end

            RUN: begin
               if (req == 7'd0) begin
                  // Let a high phase complete before parking the output low.
                  if (!wave_r || toggle) begin
                     state    <= IDLE;
                     running  <= 1'b0;
                     wave_r   <= 1'b0;
                     freq_r   <= '0;
                     phase    <= '0;
                     active   <= '0;
                     pend_vld <= 1'b0;
                  end
               end else if (req != freq_r && !pend_vld) begin
                  state   <= DIV;
                  d       <= req;
                  busy_r  <= 1'b1;
                  rem     <= '0;
                  quo     <= '0;
                  bit_idx <= 5'd24;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

   assign bus.wave     = wave_r;
   assign bus.freq_cur = freq_r;
   assign bus.busy     = busy_r;

endmodule

// File: tb/tb_tao_xung.sv
// Directed bench for tao_xung with CLK_HZ=1000 so half-periods stay short.
module tb_tao_xung;

   logic main_clk = 1'b0;
   logic rst_n    = 1'b0;
   int   total    = 0;
   int   passed   = 0;

   tao_xung_if bus ();

   tao_xung #(.CLK_HZ(1000), .FMAX(99)) dut (
      .main_clk (main_clk),
      .rst_n    (rst_n),
      .bus      (bus)
   );

   always #5 main_clk = ~main_clk;

   // Advance n cycles, sampling 1 time unit after the rising edge.
   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge main_clk);
         #1;
      end
   endtask

   // Wait for the next wave transition; n is cycles elapsed, ok=0 on timeout.
   task automatic wait_edge(input int max, output int n, output bit ok);
      logic prev;
      prev = bus.wave;
      n    = 0;
      ok   = 1'b0;
      while (n < max) begin
         cycles(1);
         n++;
         if (bus.wave !== prev) begin
            ok = 1'b1;
            break;
         end
      end
   endtask

   task automatic test_reset;
      bus.count = 7'd0;
      rst_n     = 1'b0;
      cycles(3);
      total++;
      if (bus.wave !== 1'b0) $display("FAIL reset_wave: got %0b expected 0", bus.wave);
      else passed++;
      total++;
      if (bus.freq_cur !== 7'd0) $display("FAIL reset_freq: got %0d expected 0", bus.freq_cur);
      else passed++;
      total++;
      if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", bus.busy);
      else passed++;
   endtask

   task automatic test_freq1;
      int n;
      bit ok;
      bus.count = 7'd1;
      rst_n     = 1'b1;
      n = 0;
      while (bus.busy !== 1'b1 && n < 10) begin cycles(1); n++; end
      n = 0;
      while (bus.busy === 1'b1 && n < 100) begin cycles(1); n++; end
      total++;
      if (n !== 25) $display("FAIL f1_busy_len: got %0d expected 25", n);
      else passed++;
      wait_edge(600, n, ok);
      total++;
      if (bus.freq_cur !== 7'd1) $display("FAIL f1_freq: got %0d expected 1", bus.freq_cur);
      else passed++;
      for (int i = 0; i < 2; i++) begin
         wait_edge(600, n, ok);
         total++;
         if (n !== 500) $display("FAIL f1_spacing: got %0d expected 500", n);
         else passed++;
      end
   endtask

   task automatic test_change_mid;
      int n;
      bit ok;
      cycles(100);
      bus.count = 7'd10;
      wait_edge(600, n, ok);
      total++;
      if (100 + n !== 500) $display("FAIL chg_old_half: got %0d expected 500", 100 + n);
      else passed++;
      for (int i = 0; i < 3; i++) begin
         wait_edge(100, n, ok);
         total++;
         if (n !== 50) $display("FAIL chg_new_half: got %0d expected 50", n);
         else passed++;
      end
      total++;
      if (bus.freq_cur !== 7'd10) $display("FAIL chg_freq: got %0d expected 10", bus.freq_cur);
      else passed++;
   endtask

   task automatic test_fmax;
      int n;
      bit ok;
      bus.count = 7'd99;
      cycles(100);
      wait_edge(20, n, ok);
      for (int i = 0; i < 2; i++) begin
         wait_edge(20, n, ok);
         total++;
         if (n !== 5) $display("FAIL fmax_half: got %0d expected 5", n);
         else passed++;
      end
      total++;
      if (bus.freq_cur !== 7'd99) $display("FAIL fmax_freq: got %0d expected 99", bus.freq_cur);
      else passed++;
   endtask

   task automatic test_clamp;
      int n;
      bit ok;
      bit saw_busy;
      bus.count = 7'd120;
      saw_busy  = 1'b0;
      for (int i = 0; i < 40; i++) begin
         cycles(1);
         if (bus.busy === 1'b1) saw_busy = 1'b1;
      end
      total++;
      if (saw_busy !== 1'b0) $display("FAIL clamp_no_div: got %0b expected 0", saw_busy);
      else passed++;
      wait_edge(20, n, ok);
      wait_edge(20, n, ok);
      total++;
      if (n !== 5) $display("FAIL clamp_half: got %0d expected 5", n);
      else passed++;
      total++;
      if (bus.freq_cur !== 7'd99) $display("FAIL clamp_freq: got %0d expected 99", bus.freq_cur);
      else passed++;
   endtask

   task automatic test_stop;
      int   rises;
      logic prev;
      bus.count = 7'd0;
      rises     = 0;
      prev      = bus.wave;
      for (int i = 0; i < 40; i++) begin
         cycles(1);
         if (i >= 2 && prev === 1'b0 && bus.wave === 1'b1) rises++;
         prev = bus.wave;
      end
      total++;
      if (rises !== 0) $display("FAIL stop_rises: got %0d expected 0", rises);
      else passed++;
      total++;
      if (bus.wave !== 1'b0) $display("FAIL stop_wave: got %0b expected 0", bus.wave);
      else passed++;
      total++;
      if (bus.freq_cur !== 7'd0) $display("FAIL stop_freq: got %0d expected 0", bus.freq_cur);
      else passed++;
      total++;
      if (bus.busy !== 1'b0) $display("FAIL stop_busy: got %0b expected 0", bus.busy);
      else passed++;
   endtask

   task automatic test_back_to_back;
      int   n;
      int   busy_rises;
      bit   ok;
      logic prev;
      bus.count = 7'd10;
      n = 0;
      while (bus.freq_cur !== 7'd10 && n < 200) begin cycles(1); n++; end
      total++;
      if (bus.freq_cur !== 7'd10) $display("FAIL b2b_start: got %0d expected 10", bus.freq_cur);
      else passed++;
      wait_edge(60, n, ok);
      bus.count  = 7'd20;
      busy_rises = 0;
      prev       = bus.busy;
      for (int i = 0; i < 250; i++) begin
         if (i == 10) bus.count = 7'd30;
         cycles(1);
         if (prev === 1'b0 && bus.busy === 1'b1) busy_rises++;
         prev = bus.busy;
      end
      total++;
      if (busy_rises !== 2) $display("FAIL b2b_divides: got %0d expected 2", busy_rises);
      else passed++;
      total++;
      if (bus.freq_cur !== 7'd30) $display("FAIL b2b_freq: got %0d expected 30", bus.freq_cur);
      else passed++;
      wait_edge(40, n, ok);
      for (int i = 0; i < 2; i++) begin
         wait_edge(40, n, ok);
         total++;
         if (n !== 16) $display("FAIL b2b_half: got %0d expected 16", n);
         else passed++;
      end
   endtask

   task automatic test_reset_mid;
      int n;
      bit ok;
      // Reset during a divide.
      bus.count = 7'd99;
      n = 0;
      while (bus.busy !== 1'b1 && n < 10) begin cycles(1); n++; end
      cycles(5);
      rst_n = 1'b0;
      #1;
      total++;
      if (bus.busy !== 1'b0) $display("FAIL rdiv_busy: got %0b expected 0", bus.busy);
      else passed++;
      total++;
      if (bus.freq_cur !== 7'd0) $display("FAIL rdiv_freq: got %0d expected 0", bus.freq_cur);
      else passed++;
      total++;
      if (bus.wave !== 1'b0) $display("FAIL rdiv_wave: got %0b expected 0", bus.wave);
      else passed++;
      cycles(2);
      rst_n = 1'b1;
      n = 0;
      while (bus.busy !== 1'b1 && n < 10) begin cycles(1); n++; end
      n = 0;
      while (bus.busy === 1'b1 && n < 100) begin cycles(1); n++; end
      total++;
      if (n !== 25) $display("FAIL rdiv_restart_busy: got %0d expected 25", n);
      else passed++;
      n = 0;
      while (bus.freq_cur !== 7'd99 && n < 5) begin cycles(1); n++; end
      total++;
      if (bus.freq_cur !== 7'd99) $display("FAIL rdiv_restart_freq: got %0d expected 99", bus.freq_cur);
      else passed++;
      wait_edge(20, n, ok);
      wait_edge(20, n, ok);
      total++;
      if (n !== 5) $display("FAIL rdiv_restart_half: got %0d expected 5", n);
      else passed++;
      // Reset while the wave is high.
      n = 0;
      while (bus.wave !== 1'b1 && n < 20) begin cycles(1); n++; end
      #2;
      rst_n = 1'b0;
      #1;
      total++;
      if (bus.wave !== 1'b0) $display("FAIL rrun_wave: got %0b expected 0", bus.wave);
      else passed++;
      total++;
      if (bus.freq_cur !== 7'd0) $display("FAIL rrun_freq: got %0d expected 0", bus.freq_cur);
      else passed++;
      cycles(2);
      rst_n = 1'b1;
      n = 0;
      while (bus.freq_cur !== 7'd99 && n < 60) begin cycles(1); n++; end
      total++;
      if (bus.freq_cur !== 7'd99) $display("FAIL rrun_restart_freq: got %0d expected 99", bus.freq_cur);
      else passed++;
      wait_edge(20, n, ok);
      wait_edge(20, n, ok);
      total++;
      if (n !== 5) $display("FAIL rrun_restart_half: got %0d expected 5", n);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_freq1();
      test_change_mid();
      test_fmax();
      test_clamp();
      test_stop();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
